// File: rtl/parallel_to_serial_pkg.sv
// Shared SD host defines: frame length default and parallel-to-serial FSM encoding.
package parallel_to_serial_pkg;

    // SD CMD/response frame length in bits
    localparam int unsigned P2S_WIDTH_DEFAULT = 48;

    // Level driven on the SD CMD line when nothing is being sent
    localparam logic P2S_IDLE_LEVEL = 1'b1;

    // Serializer FSM states
    typedef enum logic [1:0] {
        P2S_IDLE = 2'd0,
        P2S_SEND = 2'd1,
        P2S_DONE = 2'd2
    } p2s_state_e;

endpackage : parallel_to_serial_pkg

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter for SD CMD frames: MSB first, line idles high,
// one-cycle finished pulse after the last bit.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned WIDTH = P2S_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start_sending,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             finished,
    output logic             serial_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    p2s_state_e         state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-2:0]   shreg;
    logic               accept;
    logic               shifting;

    // A word is accepted only from IDLE; later start pulses are simply dropped
    assign accept   = (state == P2S_IDLE) && start_sending;
    // Bits remain to be shifted out while the counter is non-zero in SEND
    assign shifting = (state == P2S_SEND) && (count != '0);

    // FSM with registered serial_out and finished
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= P2S_IDLE;
            serial_out <= P2S_IDLE_LEVEL;
            finished   <= 1'b0;
        end else begin
            case (state)
                P2S_IDLE: begin
                    finished   <= 1'b0;
                    serial_out <= P2S_IDLE_LEVEL;
                    if (start_sending) begin
                        serial_out <= parallel_in[WIDTH-1];
                        state      <= P2S_SEND;
                    end
                end
                P2S_SEND: begin
                    if (count == '0) begin
                        state      <= P2S_DONE;
                        serial_out <= P2S_IDLE_LEVEL;
                        finished   <= 1'b1;
                    end else begin
                        serial_out <= shreg[WIDTH-2];
                    end
                end
                P2S_DONE: begin
                    state      <= P2S_IDLE;
                    serial_out <= P2S_IDLE_LEVEL;
                    finished   <= 1'b0;
                end
                default: begin
                    state      <= P2S_IDLE;
                    serial_out <= P2S_IDLE_LEVEL;
                    finished   <= 1'b0;
                end
            endcase
        end
    end

    // Bit counter: loaded with WIDTH-1 on accept, counts down to zero, never wraps
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (accept) begin
            count <= CNT_W'(WIDTH - 1);
        end else if (shifting) begin
            count <= count - 1'b1;
        end
    end

    // Shift register holding the bits still to send; MSB is the next bit out
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= parallel_in[WIDTH-2:0];
        end else if (shifting) begin
            shreg <= shreg << 1;
        end
    end

endmodule : parallel_to_serial

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: directed scenarios plus random
// traffic, all checked against a frame-position reference model.
module tb_parallel_to_serial;

    localparam int unsigned W = 48;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         start_sending = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         finished;
    logic         serial_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pos = -1 when idle, 0..W-1 = bit index in frame, W = completion cycle
    int           pos = -1;
    logic [W-1:0] word = '0;
    logic         exp_ser;
    logic         exp_fin;

    // Observation bookkeeping taken from DUT outputs
    int           cyc = 0;
    int           fin_count = 0;
    int           fin_cycles[$];
    logic [W-1:0] cap = '0;
    int           bits_seen = 0;

    parallel_to_serial #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start_sending (start_sending),
        .parallel_in   (parallel_in),
        .finished      (finished),
        .serial_out    (serial_out)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance the model, compare
    task automatic step(input logic rst, input logic st, input logic [W-1:0] pin, input string tag);
        RESET = rst;
        start_sending = st;
        parallel_in = pin;
        @(posedge CLK);
        #1;
        cyc++;
        if (rst) begin
            pos = -1;
        end else if (pos < 0) begin
            if (st) begin
                word = pin;
                pos = 0;
            end
        end else begin
            pos++;
            if (pos > int'(W)) pos = -1;
        end
        if (pos >= 0 && pos < int'(W)) begin
            exp_ser = word[W-1-pos];
            exp_fin = 1'b0;
            cap[W-1-pos] = serial_out;
            bits_seen++;
        end else begin
            exp_ser = 1'b1;
            exp_fin = (pos == int'(W));
        end
        if (finished === 1'b1) begin
            fin_count++;
            fin_cycles.push_back(cyc);
        end
        check({tag, "_serial"}, 64'(serial_out), 64'(exp_ser));
        check({tag, "_finished"}, 64'(finished), 64'(exp_fin));
    endtask

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wc;
        logic [W-1:0] rw;
        int f0;
        int b0;

        wa = 48'h19FA_FADB_DBF3;
        wb = 48'h12FA_FADB_DBF3;
        wc = 48'hFFFF_0000_AAAA;

        // Reset held 4 cycles with start high: line idle, nothing starts
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, wa, "reset");
        step(1'b0, 1'b0, wa, "post_reset");
        step(1'b0, 1'b0, wa, "post_reset");

        // Single word, parallel_in changed right after acceptance
        f0 = fin_count;
        b0 = bits_seen;
        step(1'b0, 1'b1, wa, "single_accept");
        for (int i = 0; i < int'(W) + 3; i++) step(1'b0, 1'b0, wb, "single");
        check("single_word_bits", 64'(cap), 64'(wa));
        check("single_fin_count", 64'(fin_count - f0), 64'd1);
        check("single_bit_count", 64'(bits_seen - b0), 64'(W));

        // Start pulse in the middle of a transfer is ignored
        rw = 48'h0123_4567_89AB;
        f0 = fin_count;
        b0 = bits_seen;
        step(1'b0, 1'b1, rw, "ignore_accept");
        for (int i = 1; i < int'(W) + 4; i++)
            step(1'b0, (i == 10), 48'hFFFF_FFFF_FFFF, "ignore");
        check("ignore_word_bits", 64'(cap), 64'(rw));
        check("ignore_fin_count", 64'(fin_count - f0), 64'd1);
        check("ignore_bit_count", 64'(bits_seen - b0), 64'(W));

        // Back-to-back words with start held high: 50-cycle period
        f0 = fin_cycles.size();
        for (int i = 0; i < 3 * 50 + 2; i++) step(1'b0, 1'b1, wc, "b2b");
        step(1'b0, 1'b0, wc, "b2b_stop");
        for (int i = 0; i < int'(W) + 3; i++) step(1'b0, 1'b0, wc, "b2b_drain");
        check("b2b_word_bits", 64'(cap), 64'(wc));
        check("b2b_fin_pulses_ge3", 64'(fin_cycles.size() - f0 >= 3), 64'd1);
        for (int k = f0 + 1; k < fin_cycles.size() && k < f0 + 3; k++)
            check("b2b_period", 64'(fin_cycles[k] - fin_cycles[k-1]), 64'd50);

        // Reset in the middle of a word: abandoned, then a full word follows
        f0 = fin_count;
        step(1'b0, 1'b1, wa, "midrst_accept");
        for (int i = 1; i < 20; i++) step(1'b0, 1'b0, wa, "midrst_pre");
        step(1'b1, 1'b0, wa, "midrst_reset");
        check("midrst_line_high", 64'(serial_out), 64'd1);
        for (int i = 0; i < int'(W) + 2; i++) step(1'b0, 1'b0, wa, "midrst_quiet");
        check("midrst_no_finish", 64'(fin_count - f0), 64'd0);
        rw = 48'h8000_0000_0001;
        b0 = bits_seen;
        step(1'b0, 1'b1, rw, "midrst_restart");
        for (int i = 0; i < int'(W) + 2; i++) step(1'b0, 1'b0, ~rw, "midrst_word");
        check("midrst_restart_bits", 64'(cap), 64'(rw));
        check("midrst_restart_count", 64'(bits_seen - b0), 64'(W));
        check("midrst_fin_count", 64'(fin_count - f0), 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rw = {$urandom(), $urandom()};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), rw, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parallel_to_serial
